// File: rtl/ram_port_master_pkg.sv
// Shared types and default widths for the RAM port sequencer.
package ram_port_master_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 16;
    localparam int BE_W       = DATA_W_DEF / 8;
    localparam int CNT_W      = 4;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ACCESS,
        HOLD,
        RESP
    } state_t;

endpackage

// File: rtl/ram_port_master_byte_merge.sv
// Byte-lane merge for read-modify-write stores: enabled lanes take new data,
// the rest keep the word read back from the RAM.
module ram_byte_merge #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0]   old_data,
    input  logic [DATA_W-1:0]   new_data,
    input  logic [DATA_W/8-1:0] be,
    output logic [DATA_W-1:0]   merged
);

    always_comb begin
        merged = old_data;
        for (int i = 0; i < DATA_W / 8; i++) begin
            if (be[i]) merged[i*8 +: 8] = new_data[i*8 +: 8];
        end
    end

endmodule

// File: rtl/ram_port_master.sv
// Valid/ready to level-sensitive RAM access sequencer, one transaction in flight.
// Optional read-modify-write for partial byte-enable stores: RAM_PORT_MASTER_RMW_EN.
//
//  state  | meaning
//  IDLE   | waiting for a request (req_ready = 1)
//  SETUP  | address driven, RW low
//  ACCESS | RW held for WAIT_CYCLES cycles
//  HOLD   | RW low, address still held
//  RESP   | response offered until rsp_ready
module ram_port_master
    import ram_port_master_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                mem_rw,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy
);

    localparam int NBE = DATA_W / 8;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

    if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
        $error("ram_port_master: WAIT_CYCLES must be in 1..15");
    end
    if (DATA_W % 8 != 0) begin : g_bad_width
        $error("ram_port_master: DATA_W must be a multiple of 8");
    end

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic             is_store;
    logic             do_write;

`ifdef RAM_PORT_MASTER_RMW_EN
    logic             rmw_read;
    logic [NBE-1:0]   be_q;
    logic [DATA_W-1:0] merged;

    // mem_wdata still holds the requested store data during the read phase
    ram_byte_merge #(.DATA_W(DATA_W)) u_merge (
        .old_data (mem_rdata),
        .new_data (mem_wdata),
        .be       (be_q),
        .merged   (merged)
    );
`else
    logic unused_be;
    assign unused_be = ^req_be;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            is_store  <= 1'b0;
            do_write  <= 1'b0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            mem_rw    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
`ifdef RAM_PORT_MASTER_RMW_EN
            rmw_read  <= 1'b0;
            be_q      <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (!req_ready) begin
                        req_ready <= 1'b1;
                    end else if (req_valid) begin
                        is_store  <= req_write;
                        mem_addr  <= req_addr;
                        mem_wdata <= req_wdata;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= SETUP;
`ifdef RAM_PORT_MASTER_RMW_EN
                        // be == 0 suppresses the write; partial be needs a read first
                        be_q      <= req_be;
                        do_write  <= req_write && (req_be != '0);
                        rmw_read  <= req_write && (req_be != '0) && (req_be != '1);
`else
                        do_write  <= req_write;
`endif
                    end
                end
                SETUP: begin
                    wait_cnt <= CNT_LOAD;
`ifdef RAM_PORT_MASTER_RMW_EN
                    mem_rw   <= do_write && !rmw_read;
`else
                    mem_rw   <= do_write;
`endif
                    state    <= ACCESS;
                end
                ACCESS: begin
                    if (wait_cnt == '0) begin
                        mem_rw    <= 1'b0;
                        rsp_rdata <= is_store ? '0 : mem_rdata;
                        state     <= HOLD;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                HOLD: begin
`ifdef RAM_PORT_MASTER_RMW_EN
                    if (rmw_read) begin
                        rmw_read  <= 1'b0;
                        mem_wdata <= merged;
                        wait_cnt  <= CNT_LOAD;
                        mem_rw    <= 1'b1;
                        state     <= ACCESS;
                    end else begin
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end
`else
                    rsp_valid <= 1'b1;
                    state     <= RESP;
`endif
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_port_master.sv
// Directed bench for ram_port_master: two instances (WAIT_CYCLES 1 and 3), each with a 16x32 RAM model.
module tb_ram_port_master;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_write [2];
    logic [15:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic [3:0]  req_be    [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_rdata [2];
    logic        mem_rw    [2];
    logic [15:0] mem_addr  [2];
    logic [31:0] mem_wdata [2];
    logic [31:0] mem_rdata [2];
    logic        busy      [2];
    logic [31:0] ram       [2][16];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        ram_port_master #(.DATA_W(32), .ADDR_W(16), .WAIT_CYCLES(g == 0 ? 1 : 3)) dut (
            .clk       (clk),
            .rst       (rst),
            .req_valid (req_valid[g]),
            .req_ready (req_ready[g]),
            .req_write (req_write[g]),
            .req_addr  (req_addr[g]),
            .req_wdata (req_wdata[g]),
            .req_be    (req_be[g]),
            .rsp_valid (rsp_valid[g]),
            .rsp_ready (rsp_ready[g]),
            .rsp_rdata (rsp_rdata[g]),
            .mem_rw    (mem_rw[g]),
            .mem_addr  (mem_addr[g]),
            .mem_wdata (mem_wdata[g]),
            .mem_rdata (mem_rdata[g]),
            .busy      (busy[g])
        );
        assign mem_rdata[g] = ram[g][mem_addr[g][3:0]];
    end

    always @(posedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (rst) begin
                for (int i = 0; i < 16; i++) ram[u][i] <= 32'hA5A5_0000 | 32'(i);
            end else if (mem_rw[u]) begin
                ram[u][mem_addr[u][3:0]] <= mem_wdata[u];
            end
        end
    end

    int n_checks = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Runs one transaction from a negedge; with hold > 0 the response is stalled and a
    // load of 0x0003 is offered meanwhile (left pending on return).
    task automatic run_txn(input int u, input logic wr, input logic [15:0] a, input logic [31:0] d,
                           input logic [3:0] be, input int hold,
                           output logic [31:0] rdata, output int lat, output int rw_cyc,
                           output logic addr_ok, output logic post_ok);
        int n;
        logic [31:0] held;
        post_ok = 1'b1;
        addr_ok = 1'b1;
        lat = 0;
        rw_cyc = 0;
        rdata = '0;
        req_write[u] = wr;
        req_addr[u]  = a;
        req_wdata[u] = d;
        req_be[u]    = be;
        req_valid[u] = 1'b1;
        rsp_ready[u] = (hold == 0);
        n = 0;
        while (!req_ready[u] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready[u]) post_ok = 1'b0;
        @(negedge clk);
        req_valid[u] = 1'b0;
        while (!rsp_valid[u] && lat < 64) begin
            lat++;
            if (mem_rw[u]) rw_cyc++;
            if (mem_addr[u] != a) addr_ok = 1'b0;
            @(negedge clk);
        end
        rdata = rsp_rdata[u];
        held = rsp_rdata[u];
        for (int i = 0; i < hold; i++) begin
            req_write[u] = 1'b0;
            req_addr[u]  = 16'h0003;
            req_valid[u] = 1'b1;
            @(negedge clk);
            if (!rsp_valid[u] || rsp_rdata[u] != held || req_ready[u] || mem_rw[u]) post_ok = 1'b0;
        end
        rsp_ready[u] = 1'b1;
        @(negedge clk);
        if (rsp_valid[u] || !req_ready[u] || busy[u]) post_ok = 1'b0;
    endtask

    typedef struct {
        int          u;
        logic        wr;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          hold;
        logic [31:0] exp_rdata;
        int          exp_lat;
        int          exp_rw;
    } vec_t;

    vec_t vecs[$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rdata;
        int lat, rw_cyc;
        logic addr_ok, post_ok, saw_rsp;

        vecs.push_back(vec_t'{0, 1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, 0, 32'h0,        3, 1});
        vecs.push_back(vec_t'{0, 1'b0, 16'h0010, 32'h0,        4'hF, 0, 32'hDEADBEEF, 3, 0});
        vecs.push_back(vec_t'{0, 1'b0, 16'h0010, 32'h0,        4'hF, 5, 32'hDEADBEEF, 3, 0});
        vecs.push_back(vec_t'{0, 1'b0, 16'h0003, 32'h0,        4'hF, 0, 32'hA5A50003, 3, 0});
        vecs.push_back(vec_t'{0, 1'b1, 16'hFFFF, 32'h12345678, 4'hF, 0, 32'h0,        3, 1});
        vecs.push_back(vec_t'{0, 1'b0, 16'hFFFF, 32'h0,        4'hF, 0, 32'h12345678, 3, 0});
        vecs.push_back(vec_t'{1, 1'b0, 16'h0007, 32'h0,        4'hF, 0, 32'hA5A50007, 5, 0});
        vecs.push_back(vec_t'{1, 1'b1, 16'h0020, 32'hCAFEF00D, 4'hF, 0, 32'h0,        5, 3});
        vecs.push_back(vec_t'{1, 1'b0, 16'h0020, 32'h0,        4'hF, 0, 32'hCAFEF00D, 5, 0});
`ifdef RAM_PORT_MASTER_RMW_EN
        vecs.push_back(vec_t'{0, 1'b1, 16'h0005, 32'h11223344, 4'hF, 0, 32'h0,        3, 1});
        vecs.push_back(vec_t'{0, 1'b1, 16'h0005, 32'hAABBCCDD, 4'h5, 0, 32'h0,        5, 1});
        vecs.push_back(vec_t'{0, 1'b0, 16'h0005, 32'h0,        4'hF, 0, 32'h11BB33DD, 3, 0});
        vecs.push_back(vec_t'{0, 1'b1, 16'h0005, 32'h99999999, 4'h0, 0, 32'h0,        3, 0});
        vecs.push_back(vec_t'{0, 1'b0, 16'h0005, 32'h0,        4'hF, 0, 32'h11BB33DD, 3, 0});
        vecs.push_back(vec_t'{1, 1'b1, 16'h0006, 32'h00000000, 4'h8, 0, 32'h0,        9, 3});
        vecs.push_back(vec_t'{1, 1'b0, 16'h0006, 32'h0,        4'hF, 0, 32'h00A50006, 5, 0});
`else
        vecs.push_back(vec_t'{0, 1'b1, 16'h0005, 32'hAABBCCDD, 4'h5, 0, 32'h0,        3, 1});
        vecs.push_back(vec_t'{0, 1'b0, 16'h0005, 32'h0,        4'hF, 0, 32'hAABBCCDD, 3, 0});
        vecs.push_back(vec_t'{0, 1'b1, 16'h0006, 32'h01020304, 4'h0, 0, 32'h0,        3, 1});
        vecs.push_back(vec_t'{0, 1'b0, 16'h0006, 32'h0,        4'hF, 0, 32'h01020304, 3, 0});
`endif

        for (int u = 0; u < 2; u++) begin
            req_valid[u] = 1'b0;
            req_write[u] = 1'b0;
            req_addr[u]  = '0;
            req_wdata[u] = '0;
            req_be[u]    = 4'hF;
            rsp_ready[u] = 1'b1;
        end

        // reset held three edges while the request side toggles
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            for (int u = 0; u < 2; u++) begin
                req_valid[u] = ~req_valid[u];
                req_write[u] = ~req_write[u];
                req_addr[u]  = 16'($urandom);
                req_wdata[u] = $urandom;
            end
        end
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            check($sformatf("reset_outputs_u%0d", u),
                  {req_ready[u], rsp_valid[u], rsp_rdata[u], mem_rw[u], mem_addr[u], mem_wdata[u], busy[u]},
                  '0);
            req_valid[u] = 1'b0;
        end
        rst = 1'b0;
        @(negedge clk);
        check("req_ready_after_reset_u0", {127'h0, req_ready[0]}, 128'h1);
        check("req_ready_after_reset_u1", {127'h0, req_ready[1]}, 128'h1);

        foreach (vecs[i]) begin
            run_txn(vecs[i].u, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be, vecs[i].hold,
                    rdata, lat, rw_cyc, addr_ok, post_ok);
            check($sformatf("v%0d_rdata", i), {96'h0, rdata}, {96'h0, vecs[i].exp_rdata});
            check($sformatf("v%0d_latency", i), 128'(lat), 128'(vecs[i].exp_lat));
            check($sformatf("v%0d_rw_cycles", i), 128'(rw_cyc), 128'(vecs[i].exp_rw));
            check($sformatf("v%0d_addr_stable", i), {127'h0, addr_ok}, 128'h1);
            check($sformatf("v%0d_handshake", i), {127'h0, post_ok}, 128'h1);
        end

        // reset in the middle of a W=3 store's access phase
        req_write[1] = 1'b1;
        req_addr[1]  = 16'h0009;
        req_wdata[1] = 32'h5555AAAA;
        req_be[1]    = 4'hF;
        req_valid[1] = 1'b1;
        @(negedge clk);
        req_valid[1] = 1'b0;
        @(negedge clk);
        check("abort_rw_in_access", {127'h0, mem_rw[1]}, 128'h1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_outputs", {124'h0, mem_rw[1], busy[1], rsp_valid[1], req_ready[1]}, 128'h0);
        rst = 1'b0;
        saw_rsp = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp_valid[1] || mem_rw[1]) saw_rsp = 1'b1;
        end
        check("abort_no_response", {127'h0, saw_rsp}, 128'h0);
        check("abort_idle", {126'h0, req_ready[1], busy[1]}, 128'h2);
        run_txn(1, 1'b0, 16'h0009, 32'h0, 4'hF, 0, rdata, lat, rw_cyc, addr_ok, post_ok);
        check("after_abort_rdata", {96'h0, rdata}, {96'h0, 32'hA5A50009});
        check("after_abort_latency", 128'(lat), 128'd5);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/ram_port_master.md
Name: ram_port_master

Overview:
- Sequencing initiator that drives the single-port, level-sensitive 16x32 RAM from a valid/ready request channel (CPU load/store unit side).
- Converts one accepted request into a safe RAM access:
  - address is set up before RW rises;
  - RW is held for a programmable number of wait cycles;
  - RW drops before the address changes.
- Returns a response on a valid/ready channel.
- Sits between the CPU datapath and the RAM instance; one outstanding transaction at a time.

Parameters:
- DATA_W, 32, data word width; must be a multiple of 8.
- ADDR_W, 16, RAM address width.
- WAIT_CYCLES, 1, cycles the access phase is held; legal range 1..15; 0 is an elaboration error.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  ADDR_W  word address.
- req_wdata  input  DATA_W  store data.
- req_be  input  DATA_W/8  byte enables; only used with the optional feature.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts response.
- rsp_rdata  output  DATA_W  load data; 0 for stores.
- mem_rw  output  1  RAM RW; 1 = write.
- mem_addr  output  ADDR_W  RAM address.
- mem_wdata  output  DATA_W  RAM data_input.
- mem_rdata  input  DATA_W  RAM data_output.
- busy  output  1  state != IDLE.

Behaviour:
- Reset values, with rst high at a clk edge:
  - state = IDLE;
  - req_ready = 0, rsp_valid = 0, rsp_rdata = 0;
  - mem_rw = 0, mem_addr = 0, mem_wdata = 0;
  - busy = 0;
  - wait counter = 0.
- req_ready is registered. It is 1 from the first cycle after reset deasserts, while in IDLE.
- Reset mid-transaction aborts the transaction. mem_rw is forced to 0 on the same edge, and any in-flight write is truncated. No response is produced for an aborted transaction.
- All outputs are registered.
- FSM states: IDLE, SETUP, ACCESS, HOLD, RESP.
  - IDLE: on req_valid && req_ready:
    - latch write, addr, wdata, be;
    - load mem_addr and mem_wdata;
    - req_ready <= 0; go to SETUP.
  - SETUP, 1 cycle:
    - mem_addr stable, mem_rw = 0;
    - counter <= WAIT_CYCLES-1; go to ACCESS.
  - ACCESS, WAIT_CYCLES cycles:
    - mem_rw = 1 for stores, 0 for loads;
    - counter decrements each cycle;
    - at counter == 0, go to HOLD.
    - For loads, rsp_rdata <= mem_rdata on the final ACCESS edge.
  - HOLD, 1 cycle:
    - mem_rw = 0, mem_addr still held;
    - rsp_valid <= 1; go to RESP.
  - RESP:
    - rsp_valid stays 1 and rsp_rdata stays stable until rsp_ready.
    - On rsp_valid && rsp_ready: rsp_valid <= 0, req_ready <= 1, go to IDLE.
- Invariants:
  - mem_addr never changes in a cycle where mem_rw = 1 or in the cycle after mem_rw falls.
  - mem_rw is never 1 outside ACCESS.
- Latency, handshake at edge E0:
  - SETUP is the cycle after E0;
  - ACCESS covers cycles E0+2 .. E0+1+W;
  - HOLD is cycle E0+2+W;
  - rsp_valid is visible in cycle E0+3+W.
  - Next req_ready is 1 no earlier than the cycle after the response handshake.
- Requests presented while req_ready = 0 are ignored; the requester holds them.
- rsp_rdata = 0 for stores.
- Address range: full ADDR_W range; no wrap or bounds check.

Optional Feature:
- Macro: RAM_PORT_MASTER_RMW_EN.
- Enabled: a store with partial req_be performs read-modify-write.
  - Read phase: SETUP, ACCESS (mem_rw = 0), HOLD. The HOLD edge captures mem_rdata.
  - Merge: bytes with be = 1 from wdata, others from the read data. The merged word is loaded into mem_wdata.
  - Write phase: ACCESS (mem_rw = 1, WAIT_CYCLES), then HOLD, then RESP.
  - Latency grows by W+1 cycles.
- Enabled, req_be all ones: plain store timing.
- Enabled, req_be == 0: no RAM write; mem_rw stays 0 and the response follows plain timing.
- Disabled: req_be is ignored and every store is a full-word write.

Decomposition:
- Package ram_port_master_pkg holds:
  - the state enum {IDLE, SETUP, ACCESS, HOLD, RESP};
  - the default width constants;
  - BE_W = DATA_W/8.
- Sub-module ram_byte_merge: combinational merge of old, new and be into the merged word. It is instantiated only under RAM_PORT_MASTER_RMW_EN.

Test Plan:
- Reset: hold rst 3 cycles while stimulus toggles -> all outputs 0. Release rst -> req_ready = 1 in the next cycle.
- W=1: store addr 0x0010 data 0xDEADBEEF, then load addr 0x0010.
  - Store: mem_rw = 1 exactly 1 cycle, with mem_addr = 0x0010 stable from SETUP through HOLD.
  - Load: rsp_rdata = 0xDEADBEEF, rsp_valid at E0+4.
- W=3: load -> mem_rw = 0 throughout; rsp_valid at E0+6. Store -> mem_rw high for exactly 3 cycles.
- Backpressure: rsp_ready = 0 for 5 cycles.
  - rsp_valid and rsp_rdata hold; req_ready stays 0.
  - A second req_valid offered in that window is not accepted until after the response handshake.
- Reset asserted during ACCESS of a store -> mem_rw = 0 the next cycle, no rsp_valid, FSM in IDLE.
- RMW_EN: word 0x11223344 at addr 5, store 0xAABBCCDD with be = 4'b0101 -> readback 0x11BB33DD. be = 0 -> word unchanged and rsp_valid still produced.
